// File: rtl/axi_node_pkg.sv
// Shared definitions for the AXI node.
//   AXI_LEN_W       : AWLEN width.
//   AXI_N_TARG_PORT : node-wide default count of initiator-side sources.
//   w_order_t       : W-order FIFO entry {one-hot source, burst length minus one}.
//   axi_strb_width(): strobe width for a given data width.
package axi_node_pkg;

    localparam int unsigned AXI_LEN_W       = 8;
    localparam int unsigned AXI_N_TARG_PORT = 8;

    typedef struct packed {
        logic [AXI_N_TARG_PORT-1:0] id;
        logic [AXI_LEN_W-1:0]       len;
    } w_order_t;

    function automatic int unsigned axi_strb_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/axi_w_allocator_dw_if.sv
// W-channel bundle of the target-side W allocator.
//   Source side : wdata_i/wstrb_i/wuser_i/wlast_i/wvalid_i (packed, source 0 at LSB), wready_o.
//   Target side : wdata_o/wstrb_o/wuser_o/wlast_o/wvalid_o, wready_i.
//   AW side     : push_ID_i, ID_i (one-hot), AWLEN_i, grant_FIFO_ID_o.
//   Status      : wlast_err_o (sticky).
// modport master : the allocator.  modport slave : the surrounding node / environment.
interface axi_w_allocator_dw_if
    import axi_node_pkg::*;
#(
    parameter int unsigned N_TARG_PORT = 8,
    parameter int unsigned AXI_DATA_W  = 64,
    parameter int unsigned AXI_USER_W  = 6
);
    localparam int unsigned AXI_STRB_W = axi_strb_width(AXI_DATA_W);

    logic [N_TARG_PORT*AXI_DATA_W-1:0] wdata_i;
    logic [N_TARG_PORT*AXI_STRB_W-1:0] wstrb_i;
    logic [N_TARG_PORT*AXI_USER_W-1:0] wuser_i;
    logic [N_TARG_PORT-1:0]            wlast_i;
    logic [N_TARG_PORT-1:0]            wvalid_i;
    logic [N_TARG_PORT-1:0]            wready_o;

    logic [AXI_DATA_W-1:0]             wdata_o;
    logic [AXI_STRB_W-1:0]             wstrb_o;
    logic [AXI_USER_W-1:0]             wuser_o;
    logic                              wlast_o;
    logic                              wvalid_o;
    logic                              wready_i;

    logic                              push_ID_i;
    logic [N_TARG_PORT-1:0]            ID_i;
    logic [AXI_LEN_W-1:0]              AWLEN_i;
    logic                              grant_FIFO_ID_o;
    logic                              wlast_err_o;

    modport master (
        input  wdata_i, wstrb_i, wuser_i, wlast_i, wvalid_i, wready_i,
        input  push_ID_i, ID_i, AWLEN_i,
        output wready_o, wdata_o, wstrb_o, wuser_o, wlast_o, wvalid_o,
        output grant_FIFO_ID_o, wlast_err_o
    );

    modport slave (
        output wdata_i, wstrb_i, wuser_i, wlast_i, wvalid_i, wready_i,
        output push_ID_i, ID_i, AWLEN_i,
        input  wready_o, wdata_o, wstrb_o, wuser_o, wlast_o, wvalid_o,
        input  grant_FIFO_ID_o, wlast_err_o
    );

endinterface

// File: rtl/axi_w_allocator_dw_fifo.sv
// generic_fifo: synchronous FIFO with valid/grant handshakes on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset
//   test_mode_i         : test mode (kept for interface compatibility; no clock gating here)
//   data_i/valid_i      : push side; push happens on valid_i & grant_o
//   grant_o             : not full; low during reset and for the first cycle after release
//   data_o/valid_o      : head entry, combinational read of the storage
//   grant_i             : pop request; pop happens on valid_o & grant_i
// A push while full or a pop while empty is ignored.
module generic_fifo #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DATA_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  test_mode_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  grant_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  grant_i
);
    localparam int unsigned PTR_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DATA_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  init_q;
    logic                  full, empty, push, pop;
    logic                  unused_test_mode;

    assign unused_test_mode = test_mode_i;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DATA_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt_q == CNT_W'(DATA_DEPTH));
    assign empty   = (cnt_q == '0);
    assign grant_o = init_q & ~full;
    assign valid_o = ~empty;
    assign data_o  = mem_q[rd_ptr_q];
    assign push    = valid_i & grant_o;
    assign pop     = grant_i & valid_o;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            init_q   <= 1'b0;
        end else begin
            init_q <= 1'b1;
            cnt_q  <= cnt_d;
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/axi_w_allocator_dw.sv
// axi_w_allocator_dw: target-side W-channel allocator.
// Forwards W beats from N_TARG_PORT sources to one target in AW-grant order. The AW arbiter
// pushes {one-hot source, AWLEN} into an order FIFO; the head entry steers a one-hot AND-OR mux
// until the source's wlast, which pops the FIFO. A beat counter flags (sticky) any wlast that
// disagrees with AWLEN without altering forwarding.
// Ports: clk, rst_n (async active-low), test_en_i, bus (axi_w_allocator_dw_if.master).
// Option: define AXI_W_ALLOC_OUT_REG_EN to insert a 2-entry spill register on the target side
// (one cycle latency, full throughput, wready_i decoupled from wready_o).
module axi_w_allocator_dw
    import axi_node_pkg::*;
#(
    parameter int unsigned N_TARG_PORT = 8,
    parameter int unsigned AXI_DATA_W  = 64,
    parameter int unsigned AXI_USER_W  = 6,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 test_en_i,
    axi_w_allocator_dw_if.master bus
);
    localparam int unsigned AXI_STRB_W = axi_strb_width(AXI_DATA_W);

    typedef struct packed {
        logic [N_TARG_PORT-1:0] id;
        logic [AXI_LEN_W-1:0]   len;
    } order_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0] data;
        logic [AXI_STRB_W-1:0] strb;
        logic [AXI_USER_W-1:0] user;
        logic                  last;
    } beat_t;

    order_t                 push_entry, head;
    logic                   valid_ID;
    logic [N_TARG_PORT-1:0] ID_int;
    logic [AXI_LEN_W-1:0]   len_int;
    beat_t                  mux_beat, out_beat;
    logic                   mux_valid, mux_ready, out_valid;
    logic                   hs, pop;
    logic [AXI_LEN_W-1:0]   beat_cnt_q;
    logic                   err_q;

    assign push_entry = '{id: bus.ID_i, len: bus.AWLEN_i};

    generic_fifo #(
        .DATA_WIDTH ($bits(order_t)),
        .DATA_DEPTH (FIFO_DEPTH)
    ) i_order_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .test_mode_i (test_en_i),
        .data_i      (push_entry),
        .valid_i     (bus.push_ID_i),
        .grant_o     (bus.grant_FIFO_ID_o),
        .data_o      (head),
        .valid_o     (valid_ID),
        .grant_i     (pop)
    );

    assign ID_int  = head.id;
    assign len_int = head.len;

    // One-hot AND-OR mux; ID_int is only trusted while valid_ID, which gates valid and ready.
    always_comb begin
        mux_beat = '0;
        for (int unsigned s = 0; s < N_TARG_PORT; s++) begin
            if (ID_int[s]) begin
                mux_beat.data |= bus.wdata_i[s*AXI_DATA_W +: AXI_DATA_W];
                mux_beat.strb |= bus.wstrb_i[s*AXI_STRB_W +: AXI_STRB_W];
                mux_beat.user |= bus.wuser_i[s*AXI_USER_W +: AXI_USER_W];
                mux_beat.last |= bus.wlast_i[s];
            end
        end
    end

    assign mux_valid    = valid_ID & |(bus.wvalid_i & ID_int);
    assign bus.wready_o = {N_TARG_PORT{mux_ready & valid_ID}} & ID_int;
    assign hs           = mux_valid & mux_ready;
    assign pop          = hs & mux_beat.last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else if (hs) begin
            if (mux_beat.last) begin
                beat_cnt_q <= '0;
                if (beat_cnt_q != len_int) err_q <= 1'b1;
            end else begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
                if (beat_cnt_q == len_int) err_q <= 1'b1;
            end
        end
    end

    assign bus.wlast_err_o = err_q;

`ifdef AXI_W_ALLOC_OUT_REG_EN
    // Two entries let the input keep accepting while the output stalls for one cycle, so
    // mux_ready depends only on registered occupancy.
    beat_t      spill_q [2];
    logic [1:0] spill_cnt_q;
    logic       spill_wr_q, spill_rd_q;
    logic       spill_push, spill_pop;

    assign mux_ready  = (spill_cnt_q != 2'd2);
    assign spill_push = hs;
    assign out_valid  = (spill_cnt_q != 2'd0);
    assign spill_pop  = out_valid & bus.wready_i;
    assign out_beat   = spill_q[spill_rd_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spill_cnt_q <= 2'd0;
            spill_wr_q  <= 1'b0;
            spill_rd_q  <= 1'b0;
        end else begin
            if (spill_push) spill_wr_q <= ~spill_wr_q;
            if (spill_pop)  spill_rd_q <= ~spill_rd_q;
            spill_cnt_q <= spill_cnt_q + {1'b0, spill_push} - {1'b0, spill_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (spill_push) spill_q[spill_wr_q] <= mux_beat;
    end
`else
    assign mux_ready = bus.wready_i;
    assign out_valid = mux_valid;
    assign out_beat  = mux_beat;
`endif

    assign bus.wvalid_o = out_valid;
    assign bus.wdata_o  = out_beat.data;
    assign bus.wstrb_o  = out_beat.strb;
    assign bus.wuser_o  = out_beat.user;
    assign bus.wlast_o  = out_beat.last;

endmodule

// File: tb/tb_axi_w_allocator_dw.sv
// Directed bench for axi_w_allocator_dw (default build: combinational forward path).
module tb_axi_w_allocator_dw;
    localparam int unsigned N  = 8;
    localparam int unsigned DW = 64;
    localparam int unsigned UW = 6;
    localparam int unsigned SW = DW / 8;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        test_en = 1'b0;
    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    axi_w_allocator_dw_if #(.N_TARG_PORT(N), .AXI_DATA_W(DW), .AXI_USER_W(UW)) bus ();

    axi_w_allocator_dw #(
        .N_TARG_PORT (N),
        .AXI_DATA_W  (DW),
        .AXI_USER_W  (UW),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .test_en_i (test_en),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] lane_data(input int s, input int b);
        return {8'(8'hA0 + s), 48'h0000_5A5A_0000, 8'(b)};
    endfunction

    function automatic logic [SW-1:0] lane_strb(input int s, input int b);
        return 8'((s * 17) ^ b);
    endfunction

    function automatic logic [UW-1:0] lane_user(input int s);
        return 6'(s + 1);
    endfunction

    task automatic idle_lanes();
        bus.wvalid_i = '0;
        bus.wlast_i  = '0;
        bus.wdata_i  = '0;
        bus.wstrb_i  = '0;
        bus.wuser_i  = '0;
    endtask

    task automatic drive_beat(input int s, input int b, input logic last);
        bus.wdata_i[s*DW +: DW] = lane_data(s, b);
        bus.wstrb_i[s*SW +: SW] = lane_strb(s, b);
        bus.wuser_i[s*UW +: UW] = lane_user(s);
        bus.wlast_i[s]          = last;
        bus.wvalid_i[s]         = 1'b1;
    endtask

    // Push takes effect on the posedge inside this task; returns at the following negedge.
    task automatic push_order(input logic [N-1:0] id, input logic [7:0] len);
        @(negedge clk);
        bus.push_ID_i = 1'b1;
        bus.ID_i      = id;
        bus.AWLEN_i   = len;
        @(negedge clk);
        bus.push_ID_i = 1'b0;
        bus.ID_i      = '0;
        bus.AWLEN_i   = '0;
    endtask

    task automatic test_reset();
        idle_lanes();
        bus.wready_i  = 1'b0;
        bus.push_ID_i = 1'b0;
        bus.ID_i      = '0;
        bus.AWLEN_i   = '0;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (bus.grant_FIFO_ID_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_grant: got %b want 1", bus.grant_FIFO_ID_o);
        end
        vectors++;
        if (bus.wvalid_o !== 1'b0 || bus.wready_o !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_valid_ready: got valid=%b ready=%h want 0/00",
                     bus.wvalid_o, bus.wready_o);
        end
        vectors++;
        if (bus.wlast_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err: got %b want 0", bus.wlast_err_o);
        end
    endtask

    task automatic test_single_burst();
        push_order(8'b0000_0100, 8'd3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            idle_lanes();
            drive_beat(2, k, k == 3);
            bus.wready_i = 1'b1;
            #1;
            vectors++;
            if (bus.wvalid_o !== 1'b1 || bus.wdata_o !== lane_data(2, k) ||
                bus.wlast_o !== (k == 3)) begin
                miscompares++;
                $display("FAIL single_beat%0d: got v=%b d=%h l=%b want 1/%h/%b", k,
                         bus.wvalid_o, bus.wdata_o, bus.wlast_o, lane_data(2, k), k == 3);
            end
            vectors++;
            if (bus.wready_o !== 8'b0000_0100 || bus.wstrb_o !== lane_strb(2, k) ||
                bus.wuser_o !== lane_user(2)) begin
                miscompares++;
                $display("FAIL single_ready_side%0d: got r=%h s=%h u=%h want 04/%h/%h", k,
                         bus.wready_o, bus.wstrb_o, bus.wuser_o, lane_strb(2, k), lane_user(2));
            end
        end
        @(negedge clk);
        idle_lanes();
        #1;
        vectors++;
        if (bus.wvalid_o !== 1'b0 || bus.wready_o !== 8'h00 || bus.wlast_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL single_end: got v=%b r=%h err=%b want 0/00/0",
                     bus.wvalid_o, bus.wready_o, bus.wlast_err_o);
        end
    endtask

    task automatic test_ordering();
        push_order(8'b0000_0010, 8'd0);
        push_order(8'b0000_0001, 8'd1);
        @(negedge clk);
        idle_lanes();
        drive_beat(1, 0, 1'b1);
        drive_beat(0, 0, 1'b0);
        bus.wready_i = 1'b1;
        #1;
        vectors++;
        if (bus.wdata_o !== lane_data(1, 0) || bus.wlast_o !== 1'b1 ||
            bus.wready_o !== 8'b0000_0010) begin
            miscompares++;
            $display("FAIL order_src1: got d=%h l=%b r=%h want %h/1/02",
                     bus.wdata_o, bus.wlast_o, bus.wready_o, lane_data(1, 0));
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            idle_lanes();
            drive_beat(0, k, k == 1);
            drive_beat(1, 5, 1'b1);  // src1 keeps offering: must not be selected now
            #1;
            vectors++;
            if (bus.wvalid_o !== 1'b1 || bus.wdata_o !== lane_data(0, k) ||
                bus.wlast_o !== (k == 1) || bus.wready_o !== 8'b0000_0001) begin
                miscompares++;
                $display("FAIL order_src0_beat%0d: got v=%b d=%h l=%b r=%h want 1/%h/%b/01", k,
                         bus.wvalid_o, bus.wdata_o, bus.wlast_o, bus.wready_o,
                         lane_data(0, k), k == 1);
            end
        end
        @(negedge clk);
        idle_lanes();
    endtask

    task automatic test_backpressure();
        int k   = 0;
        int cyc = 0;
        push_order(8'b0000_1000, 8'd7);
        while (k < 8 && cyc < 40) begin
            @(negedge clk);
            idle_lanes();
            drive_beat(3, k, k == 7);
            bus.wready_i = logic'(cyc % 2);
            #1;
            vectors++;
            if (bus.wvalid_o !== 1'b1 || bus.wdata_o !== lane_data(3, k) ||
                bus.wlast_o !== (k == 7) || bus.wready_o !== {4'b0, bus.wready_i, 3'b0}) begin
                miscompares++;
                $display("FAIL bp_cycle%0d: got v=%b d=%h l=%b r=%h want 1/%h/%b/%h", cyc,
                         bus.wvalid_o, bus.wdata_o, bus.wlast_o, bus.wready_o,
                         lane_data(3, k), k == 7, {4'b0, bus.wready_i, 3'b0});
            end
            if (bus.wready_i) k++;
            cyc++;
        end
        vectors++;
        if (k != 8) begin
            miscompares++;
            $display("FAIL bp_beats: got %0d want 8", k);
        end
        @(negedge clk);
        idle_lanes();
        bus.wready_i = 1'b1;
        #1;
        vectors++;
        if (bus.wvalid_o !== 1'b0 || bus.wlast_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_end: got v=%b err=%b want 0/0", bus.wvalid_o, bus.wlast_err_o);
        end
    endtask

    task automatic test_full_fifo();
        for (int i = 0; i < 8; i++) begin
            #1;
            vectors++;
            if (bus.grant_FIFO_ID_o !== 1'b1) begin
                miscompares++;
                $display("FAIL full_grant_before%0d: got %b want 1", i, bus.grant_FIFO_ID_o);
            end
            push_order(8'(1 << i), 8'd0);
        end
        #1;
        vectors++;
        if (bus.grant_FIFO_ID_o !== 1'b0) begin
            miscompares++;
            $display("FAIL full_grant_low: got %b want 0", bus.grant_FIFO_ID_o);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            idle_lanes();
            drive_beat(i, 0, 1'b1);
            bus.wready_i = 1'b1;
            #1;
            vectors++;
            if (bus.wdata_o !== lane_data(i, 0) || bus.wready_o !== 8'(1 << i)) begin
                miscompares++;
                $display("FAIL full_drain%0d: got d=%h r=%h want %h/%h", i,
                         bus.wdata_o, bus.wready_o, lane_data(i, 0), 8'(1 << i));
            end
            if (i < 2) begin
                vectors++;
                if (bus.grant_FIFO_ID_o !== (i == 1)) begin
                    miscompares++;
                    $display("FAIL full_grant_drain%0d: got %b want %b", i,
                             bus.grant_FIFO_ID_o, i == 1);
                end
            end
        end
        @(negedge clk);
        idle_lanes();
        #1;
        vectors++;
        if (bus.wvalid_o !== 1'b0 || bus.wready_o !== 8'h00) begin
            miscompares++;
            $display("FAIL full_empty: got v=%b r=%h want 0/00", bus.wvalid_o, bus.wready_o);
        end
    endtask

    task automatic test_len_error();
        push_order(8'b0010_0000, 8'd1);
        @(negedge clk);
        idle_lanes();
        drive_beat(5, 0, 1'b1);
        bus.wready_i = 1'b1;
        #1;
        vectors++;
        if (bus.wlast_o !== 1'b1 || bus.wlast_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL lenerr_pre: got l=%b err=%b want 1/0", bus.wlast_o, bus.wlast_err_o);
        end
        @(negedge clk);
        idle_lanes();
        #1;
        vectors++;
        if (bus.wlast_err_o !== 1'b1 || bus.wvalid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL lenerr_set: got err=%b v=%b want 1/0", bus.wlast_err_o, bus.wvalid_o);
        end
        push_order(8'b0100_0000, 8'd2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            idle_lanes();
            drive_beat(6, k, k == 2);
            #1;
            vectors++;
            if (bus.wvalid_o !== 1'b1 || bus.wdata_o !== lane_data(6, k) ||
                bus.wlast_o !== (k == 2)) begin
                miscompares++;
                $display("FAIL lenerr_next%0d: got v=%b d=%h l=%b want 1/%h/%b", k,
                         bus.wvalid_o, bus.wdata_o, bus.wlast_o, lane_data(6, k), k == 2);
            end
        end
        @(negedge clk);
        idle_lanes();
        #1;
        vectors++;
        if (bus.wlast_err_o !== 1'b1 || bus.wvalid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL lenerr_sticky: got err=%b v=%b want 1/0", bus.wlast_err_o, bus.wvalid_o);
        end
    endtask

    task automatic test_reset_mid_burst();
        push_order(8'b0001_0000, 8'd3);
        @(negedge clk);
        idle_lanes();
        drive_beat(4, 0, 1'b0);
        bus.wready_i = 1'b1;
        @(negedge clk);
        idle_lanes();
        drive_beat(4, 1, 1'b0);
        #1;
        vectors++;
        if (bus.wvalid_o !== 1'b1 || bus.wdata_o !== lane_data(4, 1)) begin
            miscompares++;
            $display("FAIL midrst_pre: got v=%b d=%h want 1/%h", bus.wvalid_o, bus.wdata_o,
                     lane_data(4, 1));
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.wvalid_o !== 1'b0 || bus.wready_o !== 8'h00 || bus.wlast_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_in_reset: got v=%b r=%h err=%b want 0/00/0",
                     bus.wvalid_o, bus.wready_o, bus.wlast_err_o);
        end
        @(negedge clk);
        idle_lanes();
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (bus.grant_FIFO_ID_o !== 1'b1 || bus.wvalid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_release: got g=%b v=%b want 1/0",
                     bus.grant_FIFO_ID_o, bus.wvalid_o);
        end
        push_order(8'b0001_0000, 8'd3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            idle_lanes();
            drive_beat(4, k, k == 3);
            #1;
            vectors++;
            if (bus.wvalid_o !== 1'b1 || bus.wdata_o !== lane_data(4, k) ||
                bus.wlast_o !== (k == 3)) begin
                miscompares++;
                $display("FAIL midrst_clean%0d: got v=%b d=%h l=%b want 1/%h/%b", k,
                         bus.wvalid_o, bus.wdata_o, bus.wlast_o, lane_data(4, k), k == 3);
            end
        end
        @(negedge clk);
        idle_lanes();
        #1;
        vectors++;
        if (bus.wvalid_o !== 1'b0 || bus.wlast_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_end: got v=%b err=%b want 0/0", bus.wvalid_o, bus.wlast_err_o);
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_ordering();
        test_backpressure();
        test_full_fifo();
        test_len_error();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
